// File: rtl/amber128_bundle_sequencer.sv
// Fetch-bundle unpacker: takes one fetch bundle of SLOT_COUNT slots, optionally
// splits flagged slots into two half-width ops, and issues the non-NOP ops to
// decode in program order, one per cycle, over a valid/ready handshake.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   flush           synchronous discard of the held bundle (branch redirect)
//   bundle_valid    fetch offers a bundle
//   bundle_ready    sequencer takes the bundle this cycle
//   bundle_addr     byte address of the offered bundle
//   bundle_data     slot i = [i*SLOT_W +: SLOT_W], split flag i = bit BUNDLE_W-SLOT_COUNT+i
//   op_valid        op presented to decode
//   op_ready        decode accepts the op
//   op_payload      full slot, or a half zero-extended to SLOT_W
//   op_is_half      op is a half-width sub-op
//   op_slot_idx     source slot index
//   op_sub_idx      0: low half / full slot, 1: high half
//   op_addr         address of the source bundle
//   op_last         final op of the bundle
module amber128_bundle_sequencer #(
    parameter int unsigned BUNDLE_W   = 128,
    parameter int unsigned SLOT_W     = 24,
    parameter int unsigned SLOT_COUNT = 5,
    parameter int unsigned SPLIT_EN   = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush,
    input  logic                          bundle_valid,
    output logic                          bundle_ready,
    input  logic [63:0]                   bundle_addr,
    input  logic [BUNDLE_W-1:0]           bundle_data,
    output logic                          op_valid,
    input  logic                          op_ready,
    output logic [SLOT_W-1:0]             op_payload,
    output logic                          op_is_half,
    output logic [$clog2(SLOT_COUNT)-1:0] op_slot_idx,
    output logic                          op_sub_idx,
    output logic [63:0]                   op_addr,
    output logic                          op_last
);

    localparam int unsigned POS_N  = 2 * SLOT_COUNT;
    localparam int unsigned POS_W  = $clog2(POS_N);
    localparam int unsigned IDX_W  = $clog2(SLOT_COUNT);
    localparam int unsigned HALF_W = SLOT_W / 2;
    localparam int unsigned PAY_W  = SLOT_COUNT * SLOT_W;
    localparam int unsigned FLAG_LSB = BUNDLE_W - SLOT_COUNT;

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_ISSUE = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [POS_N-1:0]      pm_q, pm_d;
    logic [63:0]           addr_q, addr_d;
    logic [PAY_W-1:0]      pay_q, pay_d;
    logic [SLOT_COUNT-1:0] flg_q, flg_d;

    logic [POS_N-1:0]  live_c;
    logic [SLOT_W-1:0] in_slot_c;
    logic              in_split_c;
    logic [POS_W-1:0]  low_pos_c;
    logic [IDX_W-1:0]  cur_slot_c;
    logic              cur_sub_c;
    logic [SLOT_W-1:0] cur_full_c;
    logic              cur_split_c;
    logic              issue_c;
    logic              accept_c;

    // Gap bits between payload and flags are intentionally ignored.
    logic unused_bundle_bits;
    assign unused_bundle_bits = ^bundle_data;

    // Live-position mask of the offered bundle; all-zero positions are NOPs.
    always_comb begin
        live_c     = '0;
        in_slot_c  = '0;
        in_split_c = 1'b0;
        for (int unsigned i = 0; i < SLOT_COUNT; i++) begin
            in_slot_c  = bundle_data[i*SLOT_W +: SLOT_W];
            in_split_c = (SPLIT_EN != 0) && bundle_data[FLAG_LSB + i];
            if (in_split_c) begin
                live_c[2*i]   = |in_slot_c[HALF_W-1:0];
                live_c[2*i+1] = |in_slot_c[SLOT_W-1:HALF_W];
            end else begin
                live_c[2*i]   = |in_slot_c;
            end
        end
    end

    // Lowest pending position selects the op being presented.
    always_comb begin
        low_pos_c = '0;
        for (int i = int'(POS_N) - 1; i >= 0; i--) begin
            if (pm_q[i]) begin
                low_pos_c = POS_W'(i);
            end
        end
    end

    assign cur_slot_c = IDX_W'(low_pos_c >> 1);
    assign cur_sub_c  = low_pos_c[0];

    // Fetch the held slot and its effective split flag.
    always_comb begin
        cur_full_c  = '0;
        cur_split_c = 1'b0;
        for (int unsigned i = 0; i < SLOT_COUNT; i++) begin
            if (IDX_W'(i) == cur_slot_c) begin
                cur_full_c  = pay_q[i*SLOT_W +: SLOT_W];
                cur_split_c = (SPLIT_EN != 0) && flg_q[i];
            end
        end
    end

    // Op outputs depend only on held state; forced to zero when idle.
    always_comb begin
        op_valid    = (state_q == S_ISSUE);
        op_last     = op_valid && ((pm_q & (pm_q - POS_N'(1))) == '0);
        op_sub_idx  = op_valid && cur_sub_c;
        op_is_half  = op_valid && (cur_sub_c || cur_split_c);
        op_slot_idx = op_valid ? cur_slot_c : '0;
        op_addr     = op_valid ? addr_q : '0;
        op_payload  = '0;
        if (op_valid) begin
            if (cur_sub_c) begin
                op_payload = SLOT_W'(cur_full_c[SLOT_W-1:HALF_W]);
            end else if (cur_split_c) begin
                op_payload = SLOT_W'(cur_full_c[HALF_W-1:0]);
            end else begin
                op_payload = cur_full_c;
            end
        end
    end

    // A new bundle may enter while idle or as the last op leaves (no bubble).
    assign issue_c      = op_valid && op_ready;
    assign bundle_ready = !flush && (!op_valid || (issue_c && op_last));
    assign accept_c     = bundle_valid && bundle_ready;

    // Next state: flush beats accept, accept beats issue.
    always_comb begin
        state_d = state_q;
        pm_d    = pm_q;
        addr_d  = addr_q;
        pay_d   = pay_q;
        flg_d   = flg_q;
        if (flush) begin
            pm_d = '0;
        end else if (accept_c) begin
            pm_d   = live_c;
            addr_d = bundle_addr;
            pay_d  = bundle_data[PAY_W-1:0];
            flg_d  = bundle_data[BUNDLE_W-1 -: SLOT_COUNT];
        end else if (issue_c) begin
            pm_d = pm_q & (pm_q - POS_N'(1));
        end
        state_d = (pm_d == '0) ? S_EMPTY : S_ISSUE;
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_EMPTY;
            pm_q    <= '0;
            addr_q  <= '0;
            pay_q   <= '0;
            flg_q   <= '0;
        end else begin
            state_q <= state_d;
            pm_q    <= pm_d;
            addr_q  <= addr_d;
            pay_q   <= pay_d;
            flg_q   <= flg_d;
        end
    end

endmodule

// File: tb/tb_amber128_bundle_sequencer.sv
// Self-checking bench for amber128_bundle_sequencer (default parameters plus a
// SPLIT_EN=0 instance). Inputs change 1 time unit after posedge, outputs are
// sampled on negedge.
module tb_amber128_bundle_sequencer;

    typedef struct packed {
        logic [23:0] payload;
        logic        half;
        logic [2:0]  slot;
        logic        sub;
        logic [63:0] addr;
    } op_t;

    typedef struct {
        logic [127:0] data;
        logic [63:0]  addr;
        int           n;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst, flush, bundle_valid, bundle_ready, op_ready;
    logic [63:0]  bundle_addr;
    logic [127:0] bundle_data;
    logic         op_valid, op_is_half, op_sub_idx, op_last;
    logic [23:0]  op_payload;
    logic [2:0]   op_slot_idx;
    logic [63:0]  op_addr;

    logic         d0_flush, d0_valid, d0_ready, d0_op_ready;
    logic [63:0]  d0_addr;
    logic [127:0] d0_data;
    logic         d0_op_valid, d0_is_half, d0_sub, d0_last;
    logic [23:0]  d0_payload;
    logic [2:0]   d0_slot;
    logic [63:0]  d0_op_addr;

    op_t  sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_issued = 0;
    vec_t vec[6];

    always #5 clk = ~clk;

    amber128_bundle_sequencer dut (
        .clk(clk), .rst(rst), .flush(flush),
        .bundle_valid(bundle_valid), .bundle_ready(bundle_ready),
        .bundle_addr(bundle_addr), .bundle_data(bundle_data),
        .op_valid(op_valid), .op_ready(op_ready), .op_payload(op_payload),
        .op_is_half(op_is_half), .op_slot_idx(op_slot_idx), .op_sub_idx(op_sub_idx),
        .op_addr(op_addr), .op_last(op_last)
    );

    amber128_bundle_sequencer #(.SPLIT_EN(0)) dut0 (
        .clk(clk), .rst(rst), .flush(d0_flush),
        .bundle_valid(d0_valid), .bundle_ready(d0_ready),
        .bundle_addr(d0_addr), .bundle_data(d0_data),
        .op_valid(d0_op_valid), .op_ready(d0_op_ready), .op_payload(d0_payload),
        .op_is_half(d0_is_half), .op_slot_idx(d0_slot), .op_sub_idx(d0_sub),
        .op_addr(d0_op_addr), .op_last(d0_last)
    );

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    function automatic logic [127:0] mk(input logic [23:0] s0, s1, s2, s3, s4,
                                        input logic [4:0] f);
        logic [127:0] d;
        d = '0;
        d[23:0]    = s0;
        d[47:24]   = s1;
        d[71:48]   = s2;
        d[95:72]   = s3;
        d[119:96]  = s4;
        d[127:123] = f;
        return d;
    endfunction

    // Reference model: expected op stream of one bundle, in program order.
    task automatic push_ops(input logic [127:0] d, input logic [63:0] a);
        logic [23:0] s;
        for (int i = 0; i < 5; i++) begin
            s = d[i*24 +: 24];
            if (d[123+i]) begin
                if (s[11:0] != 12'h0)  sb.push_back('{{12'h0, s[11:0]},  1'b1, 3'(i), 1'b0, a});
                if (s[23:12] != 12'h0) sb.push_back('{{12'h0, s[23:12]}, 1'b1, 3'(i), 1'b1, a});
            end else if (s != 24'h0) begin
                sb.push_back('{s, 1'b0, 3'(i), 1'b0, a});
            end
        end
    endtask

    // Scoreboard monitor: checks handshake and presented op every cycle.
    always @(negedge clk) begin
        op_t e;
        if (rst) begin
            sb.delete();
        end else begin
            chk("op_valid", op_valid, sb.size() != 0);
            chk("bundle_ready", bundle_ready,
                !flush && (sb.size() == 0 || (sb.size() == 1 && op_ready)));
            if (sb.size() != 0 && op_valid) begin
                e = sb[0];
                chk("op_fields", {op_payload, op_is_half, op_slot_idx, op_sub_idx, op_addr}, e);
                chk("op_last", op_last, sb.size() == 1);
                if (op_ready) begin
                    void'(sb.pop_front());
                    n_issued++;
                end
            end
            if (flush) sb.delete();
            else if (bundle_valid && bundle_ready) push_ops(bundle_data, bundle_addr);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [127:0] d, input logic [63:0] a);
        logic ok;
        ok = 1'b0;
        bundle_valid = 1'b1;
        bundle_data  = d;
        bundle_addr  = a;
        for (int k = 0; k < 50 && !ok; k++) begin
            @(negedge clk);
            ok = bundle_ready;
            step();
        end
        bundle_valid = 1'b0;
        chk("accept", ok, 1'b1);
    endtask

    task automatic drain();
        logic done;
        done = 1'b0;
        for (int k = 0; k < 60 && !done; k++) begin
            if (sb.size() == 0 && !op_valid) done = 1'b1;
            else step();
        end
        chk("drain", done, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [23:0] e0[5];
        logic [23:0] hp;
        logic [2:0]  hs;
        logic        ok;

        e0[0] = 24'h000001; e0[1] = 24'hABC123; e0[2] = 24'h000003;
        e0[3] = 24'h000004; e0[4] = 24'h000005;

        vec[0] = '{mk(24'h1, 24'h2, 24'h3, 24'h4, 24'h5, 5'b00000), 64'h100, 5};
        vec[1] = '{mk(24'h1, 24'hABC123, 24'h3, 24'h4, 24'h5, 5'b00010), 64'h110, 6};
        vec[2] = '{mk(24'h0, 24'h777, 24'h0, 24'h456, 24'h0, 5'b01000), 64'h120, 2};
        vec[3] = '{mk(24'h0, 24'h0, 24'h0, 24'h0, 24'h0, 5'b00000), 64'h130, 0};
        vec[4] = '{mk(24'h001002, 24'h000003, 24'h004000, 24'h005006, 24'h007008, 5'b11111),
                   64'h140, 8};
        vec[5] = '{mk(24'hFFFFFF, 24'h800000, 24'h3, 24'h4, 24'h5, 5'b00000)
                   | (128'h7 << 120), 64'h150, 5};

        rst = 1'b1; flush = 1'b0; bundle_valid = 1'b0; op_ready = 1'b1;
        bundle_addr = '0; bundle_data = '0;
        d0_flush = 1'b0; d0_valid = 1'b0; d0_op_ready = 1'b1; d0_addr = 64'h200; d0_data = '0;

        // Reset state.
        #1;
        chk("rst_op_valid", op_valid, 1'b0);
        chk("rst_op_payload", op_payload, 24'h0);
        chk("rst_op_addr", op_addr, 64'h0);
        chk("rst_op_last", op_last, 1'b0);
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", bundle_ready, 1'b1);
        step();

        // Five full ops on consecutive cycles.
        n_issued = 0;
        offer(vec[0].data, vec[0].addr);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t1_valid_run", op_valid, 1'b1);
            step();
        end
        @(negedge clk);
        chk("t1_valid_end", op_valid, 1'b0);
        chk("t1_count", n_issued, 5);
        step();

        // Table of bundles, checked op by op through the scoreboard.
        for (int v = 0; v < 6; v++) begin
            n_issued = 0;
            offer(vec[v].data, vec[v].addr);
            drain();
            chk($sformatf("vec%0d_count", v), n_issued, vec[v].n);
        end
        @(negedge clk);
        chk("idle_ready", bundle_ready, 1'b1);
        step();

        // SPLIT_EN=0: flags ignored, slot 1 stays one full op.
        d0_valid = 1'b1;
        d0_data  = vec[1].data;
        ok = 1'b0;
        for (int k = 0; k < 10 && !ok; k++) begin
            @(negedge clk);
            ok = d0_ready;
            step();
        end
        d0_valid = 1'b0;
        chk("d0_accept", ok, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("d0_valid", d0_op_valid, 1'b1);
            chk("d0_fields", {d0_payload, d0_is_half, d0_slot, d0_sub, d0_op_addr, d0_last},
                {e0[i], 1'b0, 3'(i), 1'b0, 64'h200, i == 4});
            step();
        end
        @(negedge clk);
        chk("d0_valid_end", d0_op_valid, 1'b0);
        step();

        // Back-to-back bundles with no idle cycle.
        n_issued = 0;
        bundle_valid = 1'b1;
        bundle_data  = vec[0].data;
        bundle_addr  = 64'h300;
        ok = 1'b0;
        for (int k = 0; k < 10 && !ok; k++) begin
            @(negedge clk);
            ok = bundle_ready;
            step();
        end
        chk("b2b_accept_a", ok, 1'b1);
        bundle_data = vec[4].data;
        bundle_addr = 64'h310;
        ok = 1'b0;
        for (int k = 0; k < 20 && !ok; k++) begin
            @(negedge clk);
            if (bundle_ready) begin
                chk("b2b_ready_with_last", {op_valid, op_last}, 2'b11);
                ok = 1'b1;
            end
            step();
        end
        bundle_valid = 1'b0;
        chk("b2b_accept_b", ok, 1'b1);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("b2b_valid_run", op_valid, 1'b1);
            step();
        end
        @(negedge clk);
        chk("b2b_valid_end", op_valid, 1'b0);
        chk("b2b_count", n_issued, 13);
        step();

        // Stall for three cycles mid-bundle.
        n_issued = 0;
        offer(vec[0].data, 64'h400);
        step();
        step();
        op_ready = 1'b0;
        @(negedge clk);
        hp = op_payload;
        hs = op_slot_idx;
        chk("stall_slot", hs, 3'd2);
        chk("stall_payload", hp, 24'h000003);
        step();
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("stall_hold", {op_valid, op_payload, op_slot_idx}, {1'b1, hp, hs});
            step();
        end
        op_ready = 1'b1;
        drain();
        chk("stall_count", n_issued, 5);

        // Flush mid-bundle with a bundle offered the same cycle.
        offer(vec[0].data, 64'h500);
        op_ready     = 1'b0;
        flush        = 1'b1;
        bundle_valid = 1'b1;
        bundle_data  = vec[1].data;
        @(negedge clk);
        chk("flush_ready", bundle_ready, 1'b0);
        step();
        flush        = 1'b0;
        bundle_valid = 1'b0;
        op_ready     = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("flush_valid", op_valid, 1'b0);
            step();
        end

        // Asynchronous reset mid-bundle, then normal operation.
        offer(vec[4].data, 64'h600);
        step();
        rst = 1'b1;
        #1;
        chk("arst_outputs", {op_valid, op_payload, op_addr, op_last}, '0);
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("arst_ready", bundle_ready, 1'b1);
        step();
        n_issued = 0;
        offer(vec[0].data, 64'h700);
        drain();
        chk("arst_count", n_issued, 5);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
